// File: rtl/clk_period_monitor.sv
// Simulation monitor: timestamps valid rising edges of clk_lo, tracks the reference period,
// flags and counts out-of-tolerance period changes, and records X/Z activity on the clock.
`timescale 1ps/1ps

module clk_period_monitor #(
   parameter int unsigned tolerance_p    = 1,
   parameter int unsigned skip_edges_p   = 1,
   parameter int unsigned period_width_p = 64,
   parameter int unsigned count_width_p  = 32,
   parameter int unsigned verbose_p      = 1
) (
   input  logic                      clk_lo,
   input  logic                      tag_reset,
   output logic                      period_valid_o,
   output logic [period_width_p-1:0] period_o,
   output logic                      change_o,
   output logic [count_width_p-1:0]  stable_cycles_o,
   output logic [count_width_p-1:0]  changes_o,
   output logic                      x_seen_o
);

   localparam int unsigned PW     = period_width_p;
   localparam int unsigned DW     = period_width_p + 1;
   localparam int unsigned CW     = count_width_p;
   localparam int unsigned SKIP_W = (skip_edges_p > 0) ? $clog2(skip_edges_p + 1) : 1;

   typedef enum logic [1:0] {
      ST_SKIP,
      ST_ARM,
      ST_MEASURE
   } state_t;

   localparam state_t RST_STATE = (skip_edges_p == 0) ? ST_ARM : ST_SKIP;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [SKIP_W-1:0]   r_skip;
   logic [SKIP_W-1:0]   w_skip_nxt;
   logic [63:0]         r_tprev;
   logic [63:0]         r_rel_time;
   logic                r_clk_last;
   logic                r_rst_last;
   logic                r_valid;
   logic [PW-1:0]       r_period;
   logic                r_change;
   logic [CW-1:0]       r_stable;
   logic [CW-1:0]       r_changes;
   logic                r_x_seen;

   // Period since the stored timestamp, valid only while in ST_MEASURE.
   function automatic logic [PW-1:0] cur_period();
      return PW'($time - r_tprev);
   endfunction

   // Signed, non-wrapping distance test against the reference period.
   function automatic logic is_change(input logic [PW-1:0] p_new, input logic [PW-1:0] p_ref);
      logic signed [DW-1:0] d;
      d = $signed({1'b0, p_new}) - $signed({1'b0, p_ref});
      if (d < 0) d = -d;
      return d > $signed(DW'(tolerance_p));
   endfunction

   // Phase progression applied on each valid edge.
   always_comb begin
      w_state_nxt = r_state;
      w_skip_nxt  = r_skip;
      case (r_state)
         ST_SKIP: begin
            w_skip_nxt = r_skip - SKIP_W'(1);
            if (r_skip <= SKIP_W'(1)) w_state_nxt = ST_ARM;
         end
         ST_ARM:  w_state_nxt = ST_MEASURE;
         default: w_state_nxt = ST_MEASURE;
      endcase
   end

   // Every transition of clk_lo or tag_reset is examined; only clean 0->1 after release counts.
   always_ff @(posedge clk_lo or negedge clk_lo or posedge tag_reset or negedge tag_reset) begin
      if (!tag_reset) begin
         r_state    <= RST_STATE;
         r_skip     <= SKIP_W'(skip_edges_p);
         r_tprev    <= '0;
         r_rel_time <= '0;
         r_clk_last <= clk_lo;
         r_rst_last <= 1'b0;
         r_valid    <= 1'b0;
         r_period   <= '0;
         r_change   <= 1'b0;
         r_stable   <= '0;
         r_changes  <= '0;
         r_x_seen   <= 1'b0;
      end else if (!r_rst_last) begin
         // Release instant: a coincident clock edge is deliberately dropped.
         r_rst_last <= 1'b1;
         r_rel_time <= $time;
         r_clk_last <= clk_lo;
      end else begin
         r_clk_last <= clk_lo;
         if ($isunknown(clk_lo)) begin
            r_x_seen <= 1'b1;
            if (r_state == ST_MEASURE) r_state <= ST_ARM;
         end else if (clk_lo && (r_clk_last === 1'b0) && ($time != r_rel_time)) begin
            r_state  <= w_state_nxt;
            r_skip   <= w_skip_nxt;
            r_change <= 1'b0;
            if (r_state != ST_SKIP) r_tprev <= $time;
            if (r_state == ST_MEASURE) begin
               if (!r_valid) begin
                  r_valid  <= 1'b1;
                  r_period <= cur_period();
                  r_stable <= CW'(1);
                  if (verbose_p != 0) $display("clk period %0d ps", cur_period());
               end else if (is_change(cur_period(), r_period)) begin
                  r_change <= 1'b1;
                  r_period <= cur_period();
                  r_stable <= CW'(1);
                  if (r_changes != '1) r_changes <= r_changes + CW'(1);
                  if (verbose_p != 0)
                     $display("clk period change %0d -> %0d ps", r_period, cur_period());
               end else if (r_stable != '1) begin
                  r_stable <= r_stable + CW'(1);
               end
            end
         end
      end
   end

   assign period_valid_o  = r_valid;
   assign period_o        = r_period;
   assign change_o        = r_change;
   assign stable_cycles_o = r_stable;
   assign changes_o       = r_changes;
   assign x_seen_o        = r_x_seen;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor: a table of clock gaps with expected outputs,
// followed by hand-built sequences for X, clock stop, mid-run reset, glitch and release races.
`timescale 1ps/1ps

module tb_clk_period_monitor;

   logic        clk_lo;
   logic        tag_reset;
   logic        period_valid_o;
   logic [63:0] period_o;
   logic        change_o;
   logic [31:0] stable_cycles_o;
   logic [31:0] changes_o;
   logic        x_seen_o;

   int n_vec = 0;
   int n_err = 0;
   bit fourstate;
   logic probe;

   typedef struct {
      int          gap;
      logic        v;
      logic [63:0] p;
      logic        c;
      logic [31:0] s;
      logic [31:0] n;
   } vec_t;

   vec_t vecs[15];

   clk_period_monitor #(
      .tolerance_p    (1),
      .skip_edges_p   (1),
      .period_width_p (64),
      .count_width_p  (32),
      .verbose_p      (1)
   ) dut (
      .clk_lo          (clk_lo),
      .tag_reset       (tag_reset),
      .period_valid_o  (period_valid_o),
      .period_o        (period_o),
      .change_o        (change_o),
      .stable_cycles_o (stable_cycles_o),
      .changes_o       (changes_o),
      .x_seen_o        (x_seen_o)
   );

   task automatic check(input string name, input logic ev, input logic [63:0] ep,
                        input logic ec, input logic [31:0] es, input logic [31:0] en,
                        input logic ex);
      n_vec++;
      if (period_valid_o !== ev || period_o !== ep || change_o !== ec ||
          stable_cycles_o !== es || changes_o !== en || x_seen_o !== ex) begin
         n_err++;
         $display("FAIL %s: got v=%0b p=%0d c=%0b s=%0d n=%0d x=%0b, want v=%0b p=%0d c=%0b s=%0d n=%0d x=%0b",
                  name, period_valid_o, period_o, change_o, stable_cycles_o, changes_o, x_seen_o,
                  ev, ep, ec, es, en, ex);
      end
   endtask

   // Next rising edge lands exactly gap ps after the previous one (entered 1ps after that rise).
   task automatic apply(input int gap);
      #(gap / 2 - 1) clk_lo = 1'b0;
      #(gap - gap / 2) clk_lo = 1'b1;
      #1;
   endtask

   initial begin
      probe     = 1'bx;
      fourstate = $isunknown(probe);

      vecs[0]  = '{10000, 1'b0, 64'd0,     1'b0, 32'd0, 32'd0};
      vecs[1]  = '{10000, 1'b0, 64'd0,     1'b0, 32'd0, 32'd0};
      vecs[2]  = '{10000, 1'b1, 64'd10000, 1'b0, 32'd1, 32'd0};
      vecs[3]  = '{10000, 1'b1, 64'd10000, 1'b0, 32'd2, 32'd0};
      vecs[4]  = '{10000, 1'b1, 64'd10000, 1'b0, 32'd3, 32'd0};
      vecs[5]  = '{10000, 1'b1, 64'd10000, 1'b0, 32'd4, 32'd0};
      vecs[6]  = '{10000, 1'b1, 64'd10000, 1'b0, 32'd5, 32'd0};
      vecs[7]  = '{20000, 1'b1, 64'd20000, 1'b1, 32'd1, 32'd1};
      vecs[8]  = '{20000, 1'b1, 64'd20000, 1'b0, 32'd2, 32'd1};
      vecs[9]  = '{10000, 1'b1, 64'd10000, 1'b1, 32'd1, 32'd2};
      vecs[10] = '{10001, 1'b1, 64'd10000, 1'b0, 32'd2, 32'd2};
      vecs[11] = '{ 9999, 1'b1, 64'd10000, 1'b0, 32'd3, 32'd2};
      vecs[12] = '{10002, 1'b1, 64'd10002, 1'b1, 32'd1, 32'd3};
      vecs[13] = '{10000, 1'b1, 64'd10000, 1'b1, 32'd1, 32'd4};
      vecs[14] = '{10000, 1'b1, 64'd10000, 1'b0, 32'd2, 32'd4};

      clk_lo    = 1'b0;
      tag_reset = 1'b1;
      #1 tag_reset = 1'b0;
      #1 check("reset_state", 1'b0, 64'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      clk_lo = 1'b1;
      #1 tag_reset = 1'b1;

      // Skip, arm, first period, change to 20000, tolerance band around 10000.
      for (int i = 0; i < 15; i++) begin
         apply(vecs[i].gap);
         check($sformatf("vec%0d", i), vecs[i].v, vecs[i].p, vecs[i].c, vecs[i].s, vecs[i].n, 1'b0);
      end

      // X on clk_lo during a low phase: timestamp re-armed, reference kept.
      #4999 clk_lo = 1'b0;
      #1000 if (fourstate) clk_lo = 1'bx;
      #3000 clk_lo = 1'b0;
      #1000 clk_lo = 1'b1;
      #1;
      check("x_edge1", 1'b1, 64'd10000, 1'b0, fourstate ? 32'd2 : 32'd3, 32'd4, fourstate);
      apply(10000);
      check("x_edge2", 1'b1, 64'd10000, 1'b0, fourstate ? 32'd3 : 32'd4, 32'd4, fourstate);

      // Long gap after the clock stalls is reported as a change.
      apply(60000);
      check("gap_change", 1'b1, 64'd60000, 1'b1, 32'd1, 32'd5, fourstate);
      apply(60000);
      check("gap_stable", 1'b1, 64'd60000, 1'b0, 32'd2, 32'd5, fourstate);

      // Mid-run reset clears everything immediately.
      #100 tag_reset = 1'b0;
      #1 check("reset_mid", 1'b0, 64'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      #400 tag_reset = 1'b1;

      // 2000ps glitch as first edge is absorbed by the skip phase.
      #1000 clk_lo = 1'b0;
      #500  clk_lo = 1'b1;
      #1 check("glitch_edge1", 1'b0, 64'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      #999  clk_lo = 1'b0;
      #1000 clk_lo = 1'b1;
      #1 check("glitch_edge2", 1'b0, 64'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      apply(10000);
      check("glitch_first", 1'b1, 64'd10000, 1'b0, 32'd1, 32'd0, 1'b0);
      apply(10000);
      check("glitch_stable", 1'b1, 64'd10000, 1'b0, 32'd2, 32'd0, 1'b0);

      // Reset release coincident with a rising edge: that edge must not count.
      #100 tag_reset = 1'b0;
      #1 check("reset_again", 1'b0, 64'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      #4000 clk_lo = 1'b0;
      #1000;
      tag_reset = 1'b1;
      clk_lo    = 1'b1;
      #1 check("rel_edge", 1'b0, 64'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      apply(10000);
      check("rel_skip", 1'b0, 64'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      apply(10000);
      check("rel_arm", 1'b0, 64'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      apply(10000);
      check("rel_first", 1'b1, 64'd10000, 1'b0, 32'd1, 32'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
